// File: rtl/clock_period_monitor.sv
// Samples a divided clock in the clk_in domain, emits edge strobes, measures period/high time
// and declares lock against exp_period. Optional duty measurement via `DUTY_MEASURE_EN.
module clock_period_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 0
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             div_clk,
    input  logic [CNT_W-1:0] exp_period,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TRACK   = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam int              MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
    localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q, rise_q;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [MW-1:0]          match_q, match_d;
    logic                   vld_q, vld_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   sync_lvl;
    logic [CNT_W:0]         diff;
    logic                   pass;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Widened by one bit so the absolute difference never wraps.
    always_comb begin
        if ({1'b0, cnt_q} >= {1'b0, exp_period})
            diff = {1'b0, cnt_q} - {1'b0, exp_period};
        else
            diff = {1'b0, exp_period} - {1'b0, cnt_q};
        pass = (diff <= TOL_V) && (exp_period != '0);
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        match_d   = match_q;
        vld_d     = vld_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        if (rise_q)
            cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);

        if (rise_q) begin
            timeout_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end
                ST_MEASURE: begin
                    period_d = cnt_q;
                    vld_d    = 1'b1;
                    state_d  = ST_TRACK;
                end
                default: begin
                    period_d = cnt_q;
                    if (pass) begin
                        if (match_q < LOCK_V)
                            match_d = match_q + MW'(1);
                        if (match_d == LOCK_V) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ST_TRACK;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE && cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            vld_d     = 1'b0;
            match_d   = '0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            rise_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            match_q   <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], div_clk};
            hist_q    <= sync_lvl;
            rise_q    <= sync_lvl & ~hist_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            match_q   <= match_d;
            vld_q     <= vld_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DUTY_MEASURE_EN
    logic             fall_q;
    logic [CNT_W-1:0] high_q, high_d;

    always_comb begin
        high_d = high_q;
        if (fall_q && state_q != ST_IDLE)
            high_d = cnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            fall_q <= 1'b0;
            high_q <= '0;
        end else begin
            fall_q <= ~sync_lvl & hist_q;
            high_q <= high_d;
        end
    end

    assign fall_stb  = fall_q;
    assign high_time = high_q;
`else
    assign fall_stb  = 1'b0;
    assign high_time = '0;
`endif

    assign rise_stb   = rise_q;
    assign period     = period_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed bench for clock_period_monitor: dut0 uses TOL=0, dut1 uses TOL=1, both exp_period=5.
module tb_clock_period_monitor;

    typedef struct {
        int h;
        int l;
    } per_t;

    typedef struct {
        int h;
        int l;
        int per;
        bit vld;
        bit lck;
        int hi;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div0 = 1'b0, div1 = 1'b0;
    logic [7:0] exp_p = 8'd5;

    logic       rise0, fall0, vld0, lck0, to0;
    logic [7:0] per0, hi0;
    logic       rise1, fall1, vld1, lck1, to1;
    logic [7:0] per1, hi1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   fall_seen = 0;
    per_t q0[$];
    per_t q1[$];
    vec_t tbl[23];

    always #5 clk = ~clk;

    clock_period_monitor #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(0)) dut0 (
        .clk_in(clk), .reset_n(rst_n), .div_clk(div0), .exp_period(exp_p),
        .rise_stb(rise0), .fall_stb(fall0), .period(per0), .high_time(hi0),
        .period_vld(vld0), .locked(lck0), .timeout(to0)
    );

    clock_period_monitor #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(1)) dut1 (
        .clk_in(clk), .reset_n(rst_n), .div_clk(div1), .exp_period(exp_p),
        .rise_stb(rise1), .fall_stb(fall1), .period(per1), .high_time(hi1),
        .period_vld(vld1), .locked(lck1), .timeout(to1)
    );

    always @(posedge clk) if (fall0 || fall1) fall_seen++;

    // Pattern generators: each queued entry is one period, high h then low l cycles.
    initial begin
        per_t p;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                p = q0.pop_front();
                div0 = 1'b1;
                repeat (p.h - 1) @(negedge clk);
                @(negedge clk);
                div0 = 1'b0;
                repeat (p.l - 1) @(negedge clk);
            end
        end
    end

    initial begin
        per_t p;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                p = q1.pop_front();
                div1 = 1'b1;
                repeat (p.h - 1) @(negedge clk);
                @(negedge clk);
                div1 = 1'b0;
                repeat (p.l - 1) @(negedge clk);
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_rise(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel == 0 && rise0) || (sel == 1 && rise1)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rise_wait_expired", 0, 1);
    endtask

    task automatic run_range(input int sel, input int lo, input int hi);
        bit   ok;
        per_t p;
        int   exp_hi;
        for (int k = lo; k <= hi; k++) begin
            p.h = tbl[k].h;
            p.l = tbl[k].l;
            if (sel == 0) q0.push_back(p); else q1.push_back(p);
        end
        for (int k = lo; k <= hi; k++) begin
            wait_rise(sel, ok);
            @(negedge clk);
`ifdef DUTY_MEASURE_EN
            exp_hi = tbl[k].hi;
`else
            exp_hi = 0;
`endif
            if (sel == 0) begin
                check($sformatf("t%0d_period", k), int'(per0), tbl[k].per);
                check($sformatf("t%0d_vld", k), int'(vld0), int'(tbl[k].vld));
                check($sformatf("t%0d_locked", k), int'(lck0), int'(tbl[k].lck));
                check($sformatf("t%0d_high", k), int'(hi0), exp_hi);
            end else begin
                check($sformatf("t%0d_period", k), int'(per1), tbl[k].per);
                check($sformatf("t%0d_vld", k), int'(vld1), int'(tbl[k].vld));
                check($sformatf("t%0d_locked", k), int'(lck1), int'(tbl[k].lck));
                check($sformatf("t%0d_high", k), int'(hi1), exp_hi);
            end
        end
    endtask

    initial begin
        bit   ok;
        per_t p;

        // dut0: lock at the 6th rise, lose it on a 7-cycle period, relock 4 rises later.
        for (int k = 0; k < 15; k++) tbl[k] = '{2, 3, 5, 1'b1, 1'b0, 2};
        tbl[0] = '{2, 3, 0, 1'b0, 1'b0, 0};
        for (int k = 5; k <= 8; k++) tbl[k].lck = 1'b1;
        tbl[8].l = 5;
        tbl[9].per = 7;
        tbl[13].lck = 1'b1;
        tbl[14].lck = 1'b1;
        // dut1 (TOL=1): 4/6 alternating locks, a period of 3 breaks lock.
        tbl[15] = '{2, 2, 0, 1'b0, 1'b0, 0};
        tbl[16] = '{3, 3, 4, 1'b1, 1'b0, 2};
        tbl[17] = '{2, 2, 6, 1'b1, 1'b0, 3};
        tbl[18] = '{3, 3, 4, 1'b1, 1'b0, 2};
        tbl[19] = '{2, 2, 6, 1'b1, 1'b0, 3};
        tbl[20] = '{3, 3, 4, 1'b1, 1'b1, 2};
        tbl[21] = '{1, 2, 6, 1'b1, 1'b1, 3};
        tbl[22] = '{2, 3, 3, 1'b1, 1'b0, 1};

        repeat (3) @(negedge clk);
        check("rst_period", int'(per0), 0);
        check("rst_vld", int'(vld0), 0);
        check("rst_locked", int'(lck0), 0);
        check("rst_timeout", int'(to0), 0);
        rst_n = 1'b1;

        run_range(0, 0, 14);

        // Reset while locked clears everything at that edge.
        repeat (3) @(negedge clk);
        check("pre_reset_locked", int'(lck0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_period", int'(per0), 0);
        check("reset_high", int'(hi0), 0);
        check("reset_vld", int'(vld0), 0);
        check("reset_locked", int'(lck0), 0);
        check("reset_timeout", int'(to0), 0);
        check("reset_strobes", int'(rise0) + int'(fall0), 0);
        rst_n = 1'b1;

        // Re-acquire into TRACK, then starve the input to force a timeout.
        p.h = 2;
        p.l = 3;
        repeat (3) q0.push_back(p);
        repeat (3) wait_rise(0, ok);
        @(negedge clk);
        check("track_vld", int'(vld0), 1);
        check("track_period", int'(per0), 5);
        check("track_locked", int'(lck0), 0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (to0) begin
                ok = 1'b1;
                break;
            end
        end
        check("timeout_seen", int'(ok), 1);
        check("timeout_locked", int'(lck0), 0);
        check("timeout_vld", int'(vld0), 0);

        repeat (2) q0.push_back(p);
        wait_rise(0, ok);
        @(negedge clk);
        check("post_to_timeout", int'(to0), 0);
        check("post_to_vld", int'(vld0), 0);
        wait_rise(0, ok);
        @(negedge clk);
        check("post_to_vld2", int'(vld0), 1);
        check("post_to_period", int'(per0), 5);

        run_range(1, 15, 22);

`ifdef DUTY_MEASURE_EN
        check("fall_seen", int'(fall_seen > 0), 1);
`else
        check("fall_never", fall_seen, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
